// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
//   Command and downstream-drive bundle for shift_sequencer.
//   Parameters:
//     WIDTH - data width, matches the downstream shift register (>= 2)
//     CW    - width of the shift-count field
//   Signals:
//     cmd_valid_i / cmd_ready_o - command handshake
//     cmd_word_i, cmd_dir_i, cmd_count_i, cmd_fill_i, cmd_rotate_i - command fields
//     funct_o, word_o, serial_o - drive to the downstream register
//     bit_o, bit_valid_o        - bit shifted out in each SHIFT cycle
//     mirror_o                  - copy of the downstream register contents
//     busy_o, done_o            - command in progress / one-cycle completion pulse
//   Modports: master = command issuer / observer, slave = sequencer.
interface shift_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
);
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic [WIDTH-1:0] cmd_word_i;
   logic             cmd_dir_i;
   logic [CW-1:0]    cmd_count_i;
   logic             cmd_fill_i;
   logic             cmd_rotate_i;
   logic [1:0]       funct_o;
   logic [WIDTH-1:0] word_o;
   logic             serial_o;
   logic             bit_o;
   logic             bit_valid_o;
   logic [WIDTH-1:0] mirror_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output cmd_valid_i, cmd_word_i, cmd_dir_i, cmd_count_i, cmd_fill_i, cmd_rotate_i,
      input  cmd_ready_o, funct_o, word_o, serial_o, bit_o, bit_valid_o,
             mirror_o, busy_o, done_o
   );

   modport slave (
      input  cmd_valid_i, cmd_word_i, cmd_dir_i, cmd_count_i, cmd_fill_i, cmd_rotate_i,
      output cmd_ready_o, funct_o, word_o, serial_o, bit_o, bit_valid_o,
             mirror_o, busy_o, done_o
   );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Command-driven sequencer feeding a parallel-load/shift register. Each
//   accepted command loads a word, then shifts it left or right a clamped
//   number of times with a constant fill bit or rotate-around, reporting
//   every bit shifted out and finishing with a one-cycle done pulse.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - shift_sequencer_if.slave: command handshake, downstream drive
//             (funct_o/word_o/serial_o), shifted-out bit, mirror, busy/done
module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input logic              clk,
   input logic              rst_n,
   shift_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] F_NA    = 2'b00;
   localparam logic [1:0] F_LOAD  = 2'b01;
   localparam logic [1:0] F_LEFT  = 2'b10;
   localparam logic [1:0] F_RIGHT = 2'b11;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             dir_q, dir_d;
   logic             fill_q, fill_d;
   logic             rot_q, rot_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mirror_q, mirror_d;
   logic             out_d;

   logic [1:0]       funct_q;
   logic             serial_q;
   logic             bit_q;
   logic             bit_valid_q;
   logic             busy_q;
   logic             done_q;

   // Next-state and next-mirror. Outputs are registered, so the bit that will
   // leave the register in the coming cycle is derived from the next mirror.
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      dir_d    = dir_q;
      fill_d   = fill_q;
      rot_d    = rot_q;
      cnt_d    = cnt_q;
      mirror_d = mirror_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid_i) begin
               word_d  = bus.cmd_word_i;
               dir_d   = bus.cmd_dir_i;
               fill_d  = bus.cmd_fill_i;
               rot_d   = bus.cmd_rotate_i;
               cnt_d   = (bus.cmd_count_i > CW'(WIDTH)) ? CW'(WIDTH) : bus.cmd_count_i;
               state_d = LOAD;
            end
         end
         LOAD: begin
            mirror_d = word_q;
            state_d  = (cnt_q != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            // serial_q is the serial bit presented downstream this cycle
            mirror_d = dir_q ? {serial_q, mirror_q[WIDTH-1:1]}
                             : {mirror_q[WIDTH-2:0], serial_q};
            cnt_d    = cnt_q - CW'(1);
            state_d  = (cnt_q == CW'(1)) ? DONE : SHIFT;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      out_d = dir_d ? mirror_d[0] : mirror_d[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         dir_q       <= 1'b0;
         fill_q      <= 1'b0;
         rot_q       <= 1'b0;
         cnt_q       <= '0;
         mirror_q    <= '0;
         funct_q     <= F_NA;
         serial_q    <= 1'b0;
         bit_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         dir_q       <= dir_d;
         fill_q      <= fill_d;
         rot_q       <= rot_d;
         cnt_q       <= cnt_d;
         mirror_q    <= mirror_d;
         funct_q     <= (state_d == LOAD)  ? F_LOAD :
                        (state_d == SHIFT) ? (dir_d ? F_RIGHT : F_LEFT) : F_NA;
         serial_q    <= (state_d == SHIFT) ? (rot_d ? out_d : fill_d) : 1'b0;
         bit_q       <= (state_d == SHIFT) ? out_d : 1'b0;
         bit_valid_q <= (state_d == SHIFT);
         busy_q      <= (state_d != IDLE);
         done_q      <= (state_d == DONE);
      end
   end

   assign bus.cmd_ready_o = (state_q == IDLE);
   assign bus.funct_o     = funct_q;
   assign bus.word_o      = word_q;
   assign bus.serial_o    = serial_q;
   assign bus.bit_o       = bit_q;
   assign bus.bit_valid_o = bit_valid_q;
   assign bus.mirror_o    = mirror_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;

endmodule
